// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch
// flushes and a req/done handshake that holds the pipeline around a multi-cycle MDU op.
module hazard_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RDE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDone,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MdReq,
    output logic             MdTimeout,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int WCNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MD_TIMEOUT - 1);

    typedef enum logic {IDLE, MD_WAIT} state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              set_timeout;
    logic              load_use;
    logic              stall_f, stall_d, stall_e;
    logic              flush_d, flush_e, flush_m, md_req;

    assign load_use = LoadE && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wcnt        <= '0;
            MdTimeout   <= 1'b0;
            StallCycles <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (set_timeout)
                MdTimeout <= 1'b1;
            if (StallF && (StallCycles != '1))
                StallCycles <= StallCycles + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        wcnt_nxt    = wcnt;
        set_timeout = 1'b0;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;
        md_req      = 1'b0;
        case (state)
            IDLE: begin
                // Branch wins over everything, including a simultaneous MdStartE.
                if (PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (MdStartE) begin
                    md_req    = 1'b1;
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    stall_e   = 1'b1;
                    flush_m   = 1'b1;
                    state_nxt = MD_WAIT;
                    wcnt_nxt  = '0;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MD_WAIT: begin
                if (MdDone) begin
                    state_nxt = IDLE;
                end else if (wcnt == WAIT_LAST) begin
                    // Abort: drop the op from E while F/D keep their instructions.
                    set_timeout = 1'b1;
                    stall_f     = 1'b1;
                    stall_d     = 1'b1;
                    flush_e     = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_e  = 1'b1;
                    flush_m  = 1'b1;
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mealy outputs are held low for as long as reset is asserted.
    assign StallF = reset & stall_f;
    assign StallD = reset & stall_d;
    assign StallE = reset & stall_e;
    assign FlushD = reset & flush_d;
    assign FlushE = reset & flush_e;
    assign FlushM = reset & flush_m;
    assign MdReq  = reset & md_req;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: combinational vector table in IDLE plus
// hand-written multi-cycle sequences (MDU handshake, timeout, async reset, saturation).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] RS1D, RS2D, RDE;
    logic       LoadE, PCSrcE, MdStartE, MdDone;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdReq, MdTimeout;
    logic [3:0] StallCycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdReq}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_BR   = 7'b0001100;
    localparam logic [6:0] O_MD   = 7'b1110011;
    localparam logic [6:0] O_MDW  = 7'b1110010;
    localparam logic [6:0] O_TO   = 7'b1100100;

    hazard_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .RS1D(RS1D), .RS2D(RS2D), .RDE(RDE),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MdDone(MdDone),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .MdReq(MdReq), .MdTimeout(MdTimeout), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rde;
        logic       load, pcsrc, mdstart;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [6:0] outs();
        return {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdReq};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setin(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rde,
                         input logic load, input logic pcsrc, input logic mdstart,
                         input logic mddone);
        RS1D = rs1; RS2D = rs2; RDE = rde;
        LoadE = load; PCSrcE = pcsrc; MdStartE = mdstart; MdDone = mddone;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        setin(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd3,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, O_LU};
        vecs[3]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, O_NONE};
        vecs[4]  = '{5'd5,  5'd5,  5'd5,  1'b0, 1'b0, 1'b0, O_NONE};
        vecs[5]  = '{5'd4,  5'd6,  5'd5,  1'b1, 1'b0, 1'b0, O_NONE};
        vecs[6]  = '{5'd7,  5'd1,  5'd7,  1'b1, 1'b1, 1'b0, O_BR};
        vecs[7]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, O_BR};
        vecs[8]  = '{5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 1'b1, O_MD};
        vecs[9]  = '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, O_MD};
        vecs[10] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, O_LU};

        reset = 1'b0;
        setin(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_outs", 32'(outs()), 32'(O_NONE));
        chk("reset_cnt", 32'(StallCycles), 32'd0);
        chk("reset_timeout", 32'(MdTimeout), 32'd0);
        // Outputs stay low during reset even with hazards present
        setin(5, 0, 5, 1, 0, 1, 0);
        #1 chk("reset_forced_low", 32'(outs()), 32'(O_NONE));
        setin(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;

        // Combinational table in IDLE; inputs are cleared before each edge
        for (int i = 0; i < 11; i++) begin
            cyc();
            setin(vecs[i].rs1, vecs[i].rs2, vecs[i].rde, vecs[i].load,
                  vecs[i].pcsrc, vecs[i].mdstart, 1'b0);
            #1 chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            setin(0, 0, 0, 0, 0, 0, 0);
        end
        cyc();
        chk("table_no_stall_cnt", 32'(StallCycles), 32'd0);

        // Load-use: one bubble, then RDE=0 gives none
        cyc(); setin(5, 0, 5, 1, 0, 0, 0);
        smp(); chk("lu_stall", 32'(outs()), 32'(O_LU));
        cyc(); setin(0, 0, 0, 0, 0, 0, 0);
        smp(); chk("lu_after", 32'(outs()), 32'(O_NONE));
        chk("lu_cnt", 32'(StallCycles), 32'd1);
        cyc(); setin(0, 0, 0, 1, 0, 0, 0);
        smp(); chk("lu_x0", 32'(outs()), 32'(O_NONE));
        cyc(); setin(0, 0, 0, 0, 0, 0, 0);
        smp(); chk("lu_x0_cnt", 32'(StallCycles), 32'd1);

        // Branch with a simultaneous load-use match
        cyc(); setin(5, 0, 5, 1, 1, 0, 0);
        smp(); chk("br_flush", 32'(outs()), 32'(O_BR));
        cyc(); setin(0, 0, 0, 0, 0, 0, 0);
        smp(); chk("br_cnt", 32'(StallCycles), 32'd1);

        // MDU normal: start at cycle 0, done at cycle 4; MdStartE held while E is frozen
        do_reset();
        cyc(); setin(0, 0, 0, 0, 0, 1, 0);
        smp(); chk("md_c0", 32'(outs()), 32'(O_MD));
        for (int c = 1; c <= 3; c++) begin
            cyc(); setin(5, 0, 5, 1, 1, 1, 0);
            smp(); chk($sformatf("md_c%0d", c), 32'(outs()), 32'(O_MDW));
        end
        cyc(); setin(0, 0, 0, 0, 0, 1, 1);
        smp(); chk("md_c4_done", 32'(outs()), 32'(O_NONE));
        cyc(); setin(0, 0, 0, 0, 0, 0, 0);
        smp(); chk("md_cnt", 32'(StallCycles), 32'd4);
        chk("md_idle", 32'(outs()), 32'(O_NONE));

        // MDU timeout: entry cycle 0, wait cycles 1..8 with wait count 0..7
        do_reset();
        cyc(); setin(0, 0, 0, 0, 0, 1, 0);
        smp(); chk("to_entry", 32'(outs()), 32'(O_MD));
        for (int c = 1; c <= 7; c++) begin
            cyc(); setin(0, 0, 0, 0, 0, 0, 0);
            smp(); chk($sformatf("to_wait%0d", c - 1), 32'(outs()), 32'(O_MDW));
        end
        chk("to_not_yet", 32'(MdTimeout), 32'd0);
        cyc();
        smp(); chk("to_abort", 32'(outs()), 32'(O_TO));
        cyc(); setin(0, 0, 0, 0, 0, 0, 1);
        smp(); chk("to_flag", 32'(MdTimeout), 32'd1);
        chk("to_late_done", 32'(outs()), 32'(O_NONE));
        chk("to_cnt", 32'(StallCycles), 32'd9);
        cyc(); setin(5, 0, 5, 1, 0, 0, 0);
        smp(); chk("to_idle_lu", 32'(outs()), 32'(O_LU));
        chk("to_sticky", 32'(MdTimeout), 32'd1);

        // Async reset mid-wait (MdTimeout is still 1 from the previous sequence)
        cyc(); setin(0, 0, 0, 0, 0, 1, 0);
        smp(); chk("ar_entry", 32'(outs()), 32'(O_MD));
        cyc(); setin(0, 0, 0, 0, 0, 0, 0);
        smp(); chk("ar_wait", 32'(outs()), 32'(O_MDW));
        #2 reset = 1'b0;
        #1 chk("ar_outs", 32'(outs()), 32'(O_NONE));
        chk("ar_cnt", 32'(StallCycles), 32'd0);
        chk("ar_timeout", 32'(MdTimeout), 32'd0);
        cyc(); cyc();
        #2 reset = 1'b1;
        smp(); chk("ar_idle0", 32'(outs()), 32'(O_NONE));
        cyc();
        smp(); chk("ar_idle1", 32'(outs()), 32'(O_NONE));
        chk("ar_cnt_hold", 32'(StallCycles), 32'd0);
        cyc(); setin(0, 0, 0, 0, 0, 1, 0);
        smp(); chk("ar_restart", 32'(outs()), 32'(O_MD));
        cyc(); setin(0, 0, 0, 0, 0, 0, 1);
        smp(); chk("ar_done", 32'(outs()), 32'(O_NONE));

        // Saturation: 20 consecutive load-use stalls on a 4-bit counter
        do_reset();
        cyc(); setin(5, 0, 5, 1, 0, 0, 0);
        for (int c = 0; c < 14; c++) cyc();
        smp(); chk("sat_14", 32'(StallCycles), 32'd14);
        for (int c = 0; c < 6; c++) cyc();
        setin(0, 0, 0, 0, 0, 0, 0);
        smp(); chk("sat_hold", 32'(StallCycles), 32'd15);
        cyc();
        smp(); chk("sat_final", 32'(StallCycles), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline; complements the E-stage forwarding logic.
- Covers the hazards forwarding cannot resolve: load-use (stall F/D, bubble E), taken branch/jump (flush D/E), and multi-cycle mul/div in E (hold F/D/E, bubble M via a req/done handshake with the MDU).
- Also provides a saturating stall-cycle counter and a sticky MDU timeout flag.

Parameters:
- MD_TIMEOUT, 64: maximum cycles in MD_WAIT before the operation is aborted; must be >= 2.
- CNT_W, 32: width of StallCycles.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- RS1D  input  5  rs1 of the instruction in D.
- RS2D  input  5  rs2 of the instruction in D.
- RDE  input  5  rd of the instruction in E.
- LoadE  input  1  instruction in E is a load (ResultSrcE selects memory).
- PCSrcE  input  1  taken branch/jump resolved in E.
- MdStartE  input  1  instruction in E is a multi-cycle mul/div.
- MdDone  input  1  MDU result valid; single-cycle pulse.
- StallF  output  1  hold PC.
- StallD  output  1  hold the IF/ID register.
- StallE  output  1  hold the ID/EX register.
- FlushD  output  1  clear IF/ID to a NOP.
- FlushE  output  1  clear ID/EX to a NOP.
- FlushM  output  1  clear EX/MEM to a NOP.
- MdReq  output  1  one-cycle start pulse to the MDU.
- MdTimeout  output  1  sticky: an MDU operation timed out.
- StallCycles  output  CNT_W  count of cycles with StallF=1, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; wait counter, StallCycles and MdTimeout go to 0.
  - All combinational outputs are forced to 0 while reset is low.
  - Reset asserted during MD_WAIT aborts the operation; no MdReq is issued after release.
- FSM states: IDLE, MD_WAIT. All stall/flush outputs and MdReq are Mealy outputs (combinational on state and inputs).
- IDLE, evaluated in priority order:
  1. PCSrcE=1: FlushD=1, FlushE=1, no stalls, no MdReq. This priority also covers the illegal case PCSrcE and MdStartE both high.
  2. MdStartE=1: MdReq=1, StallF=StallD=StallE=1, FlushM=1; next state MD_WAIT, wait counter cleared.
  3. Load-use, i.e. LoadE=1 & RDE!=0 & (RDE==RS1D | RDE==RS2D): StallF=1, StallD=1, FlushE=1. Exactly one bubble per matching load.
  4. Otherwise all outputs are 0.
- MD_WAIT:
  - MdDone=1: all stalls and flushes are 0 this cycle, so the mul/div advances to M; next state IDLE.
  - MdDone=0 and wait counter == MD_TIMEOUT-1: MdTimeout is set (sticky), StallF=StallD=1, FlushE=1 (kills the op); next state IDLE.
  - Otherwise StallF=StallD=StallE=1, FlushM=1, and the wait counter increments.
  - PCSrcE and load-use inputs are ignored in this state.
  - MdDone received in IDLE is ignored.
- Handshake:
  - MdReq is asserted only in the IDLE entry cycle, never in MD_WAIT.
  - Minimum operation time is 2 cycles: the entry cycle plus one MD_WAIT cycle in which MdDone can arrive.
- StallCycles: increments on each clock edge where StallF=1; holds at all-ones.

Test Plan:
- Load-use: LoadE=1, RDE=5, RS1D=5 for 1 cycle -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCycles=1. Repeat with RDE=0 -> no stall.
- Branch flush: PCSrcE=1 together with a load-use match -> FlushD=FlushE=1, StallF=0, StallCycles unchanged.
- MDU normal: MdStartE=1 at cycle 0, MdDone at cycle 4 ->
  - MdReq=1 only at cycle 0.
  - StallF/D/E=1 and FlushM=1 in cycles 0-3.
  - All outputs 0 at cycle 4; StallCycles=4.
- MDU timeout with MD_TIMEOUT=8 and no MdDone -> at wait cycle 7, StallF=StallD=FlushE=1 and MdTimeout rises and stays 1; FSM returns to IDLE; a later MdDone is ignored.
- Async reset in MD_WAIT: drop reset mid-wait -> outputs 0 immediately, StallCycles=0, MdTimeout=0; after release, IDLE with no MdReq unless MdStartE=1.
- Saturation with CNT_W=4: stall for 20 cycles -> StallCycles holds at 15.
